spi_target: RTL and testbench

SPI peripheral-mode (target) responder: the far end of the SPI master in the system bus. It lets an external SPI controller exchange bytes with on-chip logic through the same valid/ready byte-stream handshake the USB ACM path uses. SCLK, MOSI and CS_N are asynchronous to the system clock and are oversampled; one byte of buffering is provided in each direction.

---
 rtl/spi_target.sv | 204 ++++++++++++++++++++
 tb/tb_spi_target.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_target.sv
// rtl/spi_target.sv - SPI mode-0 target with oversampled pins and one byte of buffering per direction
//
// Purpose: lets an external SPI controller exchange bytes with on-chip logic
// over valid/ready byte streams. SCLK/MOSI/CS_N are asynchronous to clk and
// are oversampled through SYNC_STAGES flops plus one edge-detect flop.
//
// Ports:
//   clk, rst                     system clock, async active-low reset
//   spi_sclk, spi_mosi, spi_cs_n pin inputs from the controller (mode 0)
//   spi_miso, spi_miso_oe        pin output and its tristate enable
//   rx_data, rx_val, rx_rdy      received byte stream (toward on-chip logic)
//   tx_data, tx_val, tx_rdy      transmit byte stream (from on-chip logic)
//   rx_ovr                       one-clk pulse: a received byte was dropped
//   tx_urun                      one-clk pulse: FILL sent, no byte was queued

module spi_target #(
    parameter logic [7:0] FILL        = 8'hFF,
    parameter int         SYNC_STAGES = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       spi_sclk,
    input  logic       spi_mosi,
    input  logic       spi_cs_n,
    output logic       spi_miso,
    output logic       spi_miso_oe,
    output logic [7:0] rx_data,
    output logic       rx_val,
    input  logic       rx_rdy,
    input  logic [7:0] tx_data,
    input  logic       tx_val,
    output logic       tx_rdy,
    output logic       rx_ovr,
    output logic       tx_urun
);

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_e;

    // Pin synchronizers and edge-detect history
    logic [SYNC_STAGES-1:0] sclk_sync_q;
    logic [SYNC_STAGES-1:0] mosi_sync_q;
    logic [SYNC_STAGES-1:0] cs_sync_q;
    logic                   sclk_prev_q;
    logic                   cs_prev_q;

    logic sclk_s, mosi_s, cs_s;
    logic sclk_rise, sclk_fall, cs_fall, cs_rise;

    // Protocol state
    state_e     state_q,    state_d;
    logic [2:0] cnt_q,      cnt_d;
    logic [7:0] rx_shift_q, rx_shift_d;
    logic [7:0] tx_shift_q, tx_shift_d;
    logic [7:0] thr_q,      thr_d;
    logic       thr_full_q, thr_full_d;
    logic [7:0] rx_data_q,  rx_data_d;
    logic       rx_val_q,   rx_val_d;
    logic       rx_ovr_q,   rx_ovr_d;
    logic       tx_urun_q,  tx_urun_d;

    logic       byte_start;
    logic [7:0] rx_byte;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sclk_sync_q <= '0;
            mosi_sync_q <= '0;
            cs_sync_q   <= '1;
            sclk_prev_q <= 1'b0;
            cs_prev_q   <= 1'b1;
        end else begin
            sclk_sync_q <= {sclk_sync_q[SYNC_STAGES-2:0], spi_sclk};
            mosi_sync_q <= {mosi_sync_q[SYNC_STAGES-2:0], spi_mosi};
            cs_sync_q   <= {cs_sync_q[SYNC_STAGES-2:0], spi_cs_n};
            sclk_prev_q <= sclk_sync_q[SYNC_STAGES-1];
            cs_prev_q   <= cs_sync_q[SYNC_STAGES-1];
        end
    end

    assign sclk_s    = sclk_sync_q[SYNC_STAGES-1];
    assign mosi_s    = mosi_sync_q[SYNC_STAGES-1];
    assign cs_s      = cs_sync_q[SYNC_STAGES-1];
    assign sclk_rise = sclk_s & ~sclk_prev_q;
    assign sclk_fall = ~sclk_s & sclk_prev_q;
    assign cs_fall   = ~cs_s & cs_prev_q;
    assign cs_rise   = cs_s & ~cs_prev_q;

    assign rx_byte   = {rx_shift_q[6:0], mosi_s};

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= IDLE;
            cnt_q      <= 3'd0;
            rx_shift_q <= 8'h00;
            tx_shift_q <= 8'h00;
            thr_q      <= 8'h00;
            thr_full_q <= 1'b0;
            rx_data_q  <= 8'h00;
            rx_val_q   <= 1'b0;
            rx_ovr_q   <= 1'b0;
            tx_urun_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            rx_shift_q <= rx_shift_d;
            tx_shift_q <= tx_shift_d;
            thr_q      <= thr_d;
            thr_full_q <= thr_full_d;
            rx_data_q  <= rx_data_d;
            rx_val_q   <= rx_val_d;
            rx_ovr_q   <= rx_ovr_d;
            tx_urun_q  <= tx_urun_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        rx_shift_d = rx_shift_q;
        tx_shift_d = tx_shift_q;
        thr_d      = thr_q;
        thr_full_d = thr_full_q;
        rx_data_d  = rx_data_q;
        rx_val_d   = rx_val_q;
        rx_ovr_d   = 1'b0;
        tx_urun_d  = 1'b0;
        byte_start = 1'b0;

        if (tx_val && !thr_full_q) begin
            thr_d      = tx_data;
            thr_full_d = 1'b1;
        end

        if (rx_val_q && rx_rdy) begin
            rx_val_d = 1'b0;
        end

        case (state_q)
            IDLE: begin
                if (cs_fall) begin
                    state_d    = SHIFT;
                    byte_start = 1'b1;
                end
            end
            SHIFT: begin
                if (cs_rise) begin
                    // Abandon the partial byte in both directions; THR survives.
                    state_d    = IDLE;
                    cnt_d      = 3'd0;
                    rx_shift_d = 8'h00;
                    tx_shift_d = 8'h00;
                end else begin
                    if (sclk_rise) begin
                        rx_shift_d = rx_byte;
                        cnt_d      = cnt_q + 3'd1;
                        if (cnt_q == 3'd7) begin
                            // A consumer accepting this very clk frees the slot.
                            if (rx_val_q && !rx_rdy) begin
                                rx_ovr_d = 1'b1;
                            end else begin
                                rx_data_d = rx_byte;
                                rx_val_d  = 1'b1;
                            end
                        end
                    end
                    if (sclk_fall) begin
                        // Counter back at 0 on a fall means 8 bits have gone out.
                        if (cnt_q == 3'd0) begin
                            byte_start = 1'b1;
                        end else begin
                            tx_shift_d = {tx_shift_q[6:0], 1'b0};
                        end
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        // Reload decision uses the registered THR state, so a byte written
        // in the same clk as an empty-THR reload waits for the next byte.
        if (byte_start) begin
            cnt_d = 3'd0;
            if (thr_full_q) begin
                tx_shift_d = thr_q;
                thr_full_d = 1'b0;
            end else begin
                tx_shift_d = FILL;
                tx_urun_d  = 1'b1;
            end
        end
    end

    assign spi_miso    = tx_shift_q[7];
    assign spi_miso_oe = (state_q == SHIFT);
    assign rx_data     = rx_data_q;
    assign rx_val      = rx_val_q;
    assign tx_rdy      = ~thr_full_q;
    assign rx_ovr      = rx_ovr_q;
    assign tx_urun     = tx_urun_q;

endmodule

// File: tb/tb_spi_target.sv
// tb/tb_spi_target.sv - directed self-checking bench for spi_target

module tb_spi_target;

    logic       clk;
    logic       rst;
    logic       spi_sclk;
    logic       spi_mosi;
    logic       spi_cs_n;
    logic       spi_miso;
    logic       spi_miso_oe;
    logic [7:0] rx_data;
    logic       rx_val;
    logic       rx_rdy;
    logic [7:0] tx_data;
    logic       tx_val;
    logic       tx_rdy;
    logic       rx_ovr;
    logic       tx_urun;

    int n_checks;
    int n_fail;

    int         ovr_cnt;
    int         urun_cnt;
    int         acc_cnt;
    logic [7:0] last_acc;

    spi_target dut (
        .clk         (clk),
        .rst         (rst),
        .spi_sclk    (spi_sclk),
        .spi_mosi    (spi_mosi),
        .spi_cs_n    (spi_cs_n),
        .spi_miso    (spi_miso),
        .spi_miso_oe (spi_miso_oe),
        .rx_data     (rx_data),
        .rx_val      (rx_val),
        .rx_rdy      (rx_rdy),
        .tx_data     (tx_data),
        .tx_val      (tx_val),
        .tx_rdy      (tx_rdy),
        .rx_ovr      (rx_ovr),
        .tx_urun     (tx_urun)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        ovr_cnt  = 0;
        urun_cnt = 0;
        acc_cnt  = 0;
        last_acc = 8'h00;
    end

    always @(negedge clk) begin
        if (rx_ovr === 1'b1)  ovr_cnt  = ovr_cnt + 1;
        if (tx_urun === 1'b1) urun_cnt = urun_cnt + 1;
        if (rx_val === 1'b1 && rx_rdy === 1'b1) begin
            acc_cnt  = acc_cnt + 1;
            last_acc = rx_data;
        end
    end

    task automatic wait_clks(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic cs_low();
        spi_cs_n = 1'b0;
        wait_clks(6);
    endtask

    task automatic cs_high();
        wait_clks(6);
        spi_cs_n = 1'b1;
        wait_clks(6);
    endtask

    // Mode-0 controller: data set while sclk low, MISO sampled at the rise.
    task automatic spi_bits(input logic [7:0] mo, input int n, output logic [7:0] mi);
        mi = 8'h00;
        for (int i = 0; i < n; i++) begin
            spi_mosi = mo[7-i];
            wait_clks(4);
            spi_sclk = 1'b1;
            mi = {mi[6:0], spi_miso};
            wait_clks(4);
            spi_sclk = 1'b0;
        end
        wait_clks(6);
    endtask

    task automatic tx_push(input logic [7:0] b);
        int k;
        k = 0;
        while (tx_rdy !== 1'b1 && k < 50) begin
            wait_clks(1);
            k++;
        end
        n_checks++;
        if (tx_rdy !== 1'b1) begin
            n_fail++;
            $display("FAIL tx_push_timeout tx_rdy=%b exp 1", tx_rdy);
        end
        tx_data = b;
        tx_val  = 1'b1;
        wait_clks(1);
        tx_val  = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        wait_clks(3);
        n_checks++; if (rx_data !== 8'h00) begin n_fail++; $display("FAIL rst_rx_data got %h exp 00", rx_data); end
        n_checks++; if (rx_val !== 1'b0) begin n_fail++; $display("FAIL rst_rx_val got %b exp 0", rx_val); end
        n_checks++; if (tx_rdy !== 1'b1) begin n_fail++; $display("FAIL rst_tx_rdy got %b exp 1", tx_rdy); end
        n_checks++; if (spi_miso !== 1'b0) begin n_fail++; $display("FAIL rst_miso got %b exp 0", spi_miso); end
        n_checks++; if (spi_miso_oe !== 1'b0) begin n_fail++; $display("FAIL rst_miso_oe got %b exp 0", spi_miso_oe); end
        n_checks++; if (rx_ovr !== 1'b0 || tx_urun !== 1'b0) begin n_fail++; $display("FAIL rst_flags got %b%b exp 00", rx_ovr, tx_urun); end
        rst = 1'b1;
        wait_clks(10);
        n_checks++; if (spi_miso_oe !== 1'b0) begin n_fail++; $display("FAIL idle_miso_oe got %b exp 0", spi_miso_oe); end
        n_checks++; if (tx_rdy !== 1'b1) begin n_fail++; $display("FAIL idle_tx_rdy got %b exp 1", tx_rdy); end
    endtask

    task automatic test_single_byte();
        logic [7:0] mi;
        int o0, u0;
        o0 = ovr_cnt; u0 = urun_cnt;
        rx_rdy = 1'b0;
        tx_push(8'hA5);
        n_checks++; if (tx_rdy !== 1'b0) begin n_fail++; $display("FAIL single_thr_full tx_rdy=%b exp 0", tx_rdy); end
        cs_low();
        n_checks++; if (spi_miso_oe !== 1'b1) begin n_fail++; $display("FAIL single_miso_oe got %b exp 1", spi_miso_oe); end
        n_checks++; if (tx_rdy !== 1'b1) begin n_fail++; $display("FAIL single_thr_moved tx_rdy=%b exp 1", tx_rdy); end
        // Queue the following byte so the end-of-byte reload has data.
        tx_push(8'hC3);
        spi_bits(8'h3C, 8, mi);
        n_checks++; if (mi !== 8'hA5) begin n_fail++; $display("FAIL single_miso got %h exp a5", mi); end
        n_checks++; if (rx_data !== 8'h3C || rx_val !== 1'b1) begin n_fail++; $display("FAIL single_rx got %h/%b exp 3c/1", rx_data, rx_val); end
        n_checks++; if (ovr_cnt != o0 || urun_cnt != u0) begin n_fail++; $display("FAIL single_flags ovr=%0d urun=%0d exp 0/0", ovr_cnt - o0, urun_cnt - u0); end
        cs_high();
        n_checks++; if (tx_rdy !== 1'b1) begin n_fail++; $display("FAIL single_tx_rdy_end got %b exp 1", tx_rdy); end
        n_checks++; if (spi_miso_oe !== 1'b0) begin n_fail++; $display("FAIL single_oe_end got %b exp 0", spi_miso_oe); end
        rx_rdy = 1'b1;
        wait_clks(1);
        rx_rdy = 1'b0;
        wait_clks(1);
        n_checks++; if (rx_val !== 1'b0) begin n_fail++; $display("FAIL single_consume rx_val=%b exp 0", rx_val); end
    endtask

    task automatic test_back_to_back();
        logic [7:0] mi;
        int u0;
        tx_push(8'h96);
        u0 = urun_cnt;
        cs_low();
        spi_bits(8'h12, 8, mi);
        n_checks++; if (mi !== 8'h96) begin n_fail++; $display("FAIL b2b_miso0 got %h exp 96", mi); end
        n_checks++; if (rx_data !== 8'h12 || rx_val !== 1'b1) begin n_fail++; $display("FAIL b2b_rx0 got %h/%b exp 12/1", rx_data, rx_val); end
        n_checks++; if (urun_cnt - u0 != 1) begin n_fail++; $display("FAIL b2b_urun got %0d exp 1", urun_cnt - u0); end
        rx_rdy = 1'b1;
        wait_clks(1);
        rx_rdy = 1'b0;
        spi_bits(8'h34, 8, mi);
        n_checks++; if (mi !== 8'hFF) begin n_fail++; $display("FAIL b2b_miso1 got %h exp ff", mi); end
        n_checks++; if (rx_data !== 8'h34 || rx_val !== 1'b1) begin n_fail++; $display("FAIL b2b_rx1 got %h/%b exp 34/1", rx_data, rx_val); end
        cs_high();
        rx_rdy = 1'b1;
        wait_clks(2);
        rx_rdy = 1'b0;
    endtask

    task automatic test_overrun();
        logic [7:0] mi;
        int o0, a0;
        rx_rdy = 1'b0;
        o0 = ovr_cnt;
        cs_low();
        spi_bits(8'h11, 8, mi);
        n_checks++; if (rx_data !== 8'h11 || rx_val !== 1'b1) begin n_fail++; $display("FAIL ovr_first got %h/%b exp 11/1", rx_data, rx_val); end
        spi_bits(8'h22, 8, mi);
        n_checks++; if (rx_data !== 8'h11) begin n_fail++; $display("FAIL ovr_held got %h exp 11", rx_data); end
        n_checks++; if (ovr_cnt - o0 != 1) begin n_fail++; $display("FAIL ovr_pulse got %0d exp 1", ovr_cnt - o0); end
        // Consumer ready through the next completion: old byte out, new byte in, no drop.
        o0 = ovr_cnt;
        a0 = acc_cnt;
        rx_rdy = 1'b1;
        spi_bits(8'h22, 8, mi);
        cs_high();
        n_checks++; if (rx_data !== 8'h22) begin n_fail++; $display("FAIL ovr_rdy_data got %h exp 22", rx_data); end
        n_checks++; if (acc_cnt - a0 != 2 || last_acc !== 8'h22) begin n_fail++; $display("FAIL ovr_rdy_acc got %0d/%h exp 2/22", acc_cnt - a0, last_acc); end
        n_checks++; if (ovr_cnt != o0) begin n_fail++; $display("FAIL ovr_rdy_noflag got %0d exp 0", ovr_cnt - o0); end
    endtask

    task automatic test_partial_abort();
        logic [7:0] mi;
        int a0;
        rx_rdy = 1'b0;
        a0 = acc_cnt;
        cs_low();
        tx_push(8'h69);
        spi_bits(8'hFF, 5, mi);
        cs_high();
        n_checks++; if (rx_val !== 1'b0) begin n_fail++; $display("FAIL partial_rx_val got %b exp 0", rx_val); end
        n_checks++; if (tx_rdy !== 1'b0) begin n_fail++; $display("FAIL partial_thr_kept tx_rdy=%b exp 0", tx_rdy); end
        cs_low();
        spi_bits(8'h5A, 8, mi);
        cs_high();
        n_checks++; if (mi !== 8'h69) begin n_fail++; $display("FAIL partial_miso got %h exp 69", mi); end
        n_checks++; if (rx_data !== 8'h5A || rx_val !== 1'b1) begin n_fail++; $display("FAIL partial_rx got %h/%b exp 5a/1", rx_data, rx_val); end
        n_checks++; if (acc_cnt != a0) begin n_fail++; $display("FAIL partial_acc got %0d exp 0", acc_cnt - a0); end
    endtask

    task automatic test_reset_mid_byte();
        logic [7:0] mi;
        tx_push(8'h77);
        cs_low();
        tx_push(8'h88);
        spi_bits(8'hF0, 3, mi);
        #1;
        rst      = 1'b0;
        spi_cs_n = 1'b1;
        spi_sclk = 1'b0;
        spi_mosi = 1'b0;
        #1;
        n_checks++; if (rx_data !== 8'h00 || rx_val !== 1'b0) begin n_fail++; $display("FAIL midrst_rx got %h/%b exp 00/0", rx_data, rx_val); end
        n_checks++; if (tx_rdy !== 1'b1) begin n_fail++; $display("FAIL midrst_tx_rdy got %b exp 1", tx_rdy); end
        n_checks++; if (spi_miso_oe !== 1'b0 || spi_miso !== 1'b0) begin n_fail++; $display("FAIL midrst_miso got oe=%b miso=%b exp 0/0", spi_miso_oe, spi_miso); end
        wait_clks(3);
        rst = 1'b1;
        wait_clks(4);
        rx_rdy = 1'b0;
        tx_push(8'hE7);
        cs_low();
        spi_bits(8'h9C, 8, mi);
        cs_high();
        n_checks++; if (mi !== 8'hE7) begin n_fail++; $display("FAIL midrst_after_miso got %h exp e7", mi); end
        n_checks++; if (rx_data !== 8'h9C || rx_val !== 1'b1) begin n_fail++; $display("FAIL midrst_after_rx got %h/%b exp 9c/1", rx_data, rx_val); end
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        rst      = 1'b0;
        spi_sclk = 1'b0;
        spi_mosi = 1'b0;
        spi_cs_n = 1'b1;
        rx_rdy   = 1'b0;
        tx_data  = 8'h00;
        tx_val   = 1'b0;
        test_reset();
        test_single_byte();
        test_back_to_back();
        test_overrun();
        test_partial_abort();
        test_reset_mid_byte();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
